// File: rtl/c2h_sched_pkg.sv
// rtl/c2h_sched_pkg.sv - shared types and helpers for the C2H queue scheduler
package c2h_sched_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_XFER} sched_state_t;

  // Queue index width; a single-bit index is kept even for tiny queue counts.
  function automatic int qid_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Computes a + b - dec, clamped to max. Callers guarantee a >= dec, so no underflow.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        dec,
                                          input logic [31:0] max);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b} - {32'b0, dec};
    if (s > {1'b0, max}) return max;
    return s[31:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a pointer
// Purpose: returns the first asserted request at or after ptr, wrapping at N-1.
// Ports: req (N requests), ptr (search start), gnt (one-hot), idx (granted index), vld (any grant).
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          vld
);

  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!vld && req[j]) begin
        vld    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/c2h_queue_sched.sv
// rtl/c2h_queue_sched.sv - packet-granular round-robin C2H stream scheduler with per-queue credits
// Purpose: shares one C2H AXI-ST port among NUM_Q generators; a queue is granted only with credit
//   and keeps the grant until its last beat.
// Ports: axi_aclk/axi_aresetn clock and async reset; q_enable per-queue enable; credit_updt/credit_qid/
//   credit_in credit return; s_* per-queue source streams; m_* muxed stream to C2H (m_ready from C2H);
//   m_qid granted queue; credit_avail per-queue credit counters.
module c2h_queue_sched
  import c2h_sched_pkg::*;
#(
  parameter int NUM_Q       = 4,
  parameter int RX_LEN      = 512,
  parameter int RX_BEN      = RX_LEN / 8,
  parameter int TM_DSC_BITS = 16,
  parameter int QID_W       = qid_width(NUM_Q)
) (
  input  logic                         axi_aclk,
  input  logic                         axi_aresetn,
  input  logic [NUM_Q-1:0]             q_enable,
  input  logic                         credit_updt,
  input  logic [QID_W-1:0]             credit_qid,
  input  logic [TM_DSC_BITS-1:0]       credit_in,
  input  logic [NUM_Q-1:0]             s_valid,
  input  logic [NUM_Q*RX_LEN-1:0]      s_data,
  input  logic [NUM_Q*RX_BEN-1:0]      s_ben,
  input  logic [NUM_Q-1:0]             s_last,
  output logic [NUM_Q-1:0]             s_ready,
  input  logic                         m_ready,
  output logic                         m_valid,
  output logic [RX_LEN-1:0]            m_data,
  output logic [RX_BEN-1:0]            m_ben,
  output logic                         m_last,
  output logic [QID_W-1:0]             m_qid,
  output logic [NUM_Q*TM_DSC_BITS-1:0] credit_avail
);

  localparam logic [31:0] CRED_MAX = 32'((64'd1 << TM_DSC_BITS) - 64'd1);

  sched_state_t     state, state_nxt;
  logic [QID_W-1:0] grant, grant_nxt;
  logic [QID_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [NUM_Q-1:0] cred_nz;
  logic [NUM_Q-1:0] eligible;
  logic [NUM_Q-1:0] arb_gnt;
  logic [QID_W-1:0] arb_idx;
  logic             arb_vld;
  logic             take;

  assign eligible = q_enable & s_valid & cred_nz;
  // A grant is only taken in ARB; the arbiter output is ignored elsewhere.
  assign take     = (state == S_ARB) && arb_vld;

  rr_arbiter #(.N(NUM_Q), .IW(QID_W)) u_arb (
    .req (eligible),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .vld (arb_vld)
  );

  // Credit counters: disabled queues sit at zero and ignore returns; an update and a
  // grant landing together net to credit + credit_in - 1, clamped at all-ones.
  for (genvar i = 0; i < NUM_Q; i++) begin : g_credit
    logic [TM_DSC_BITS-1:0] cnt;
    logic                   upd;
    logic                   con;

    assign upd = credit_updt && (int'(credit_qid) == i);
    assign con = take && arb_gnt[i];

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn)     cnt <= '0;
      else if (!q_enable[i]) cnt <= '0;
      else                  cnt <= TM_DSC_BITS'(sat_add(32'(cnt), upd ? 32'(credit_in) : 32'd0,
                                                       con, CRED_MAX));
    end

    assign cred_nz[i] = |cnt;
    assign credit_avail[i*TM_DSC_BITS +: TM_DSC_BITS] = cnt;
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state  <= S_IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    rr_ptr_nxt = rr_ptr;
    s_ready    = '0;
    m_valid    = 1'b0;
    m_last     = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_ARB;
      S_ARB: begin
        if (arb_vld) begin
          grant_nxt = arb_idx;
          state_nxt = S_XFER;
        end
      end
      S_XFER: begin
        m_valid        = s_valid[grant];
        m_last         = s_last[grant];
        s_ready[grant] = m_ready;
        if (s_valid[grant] && m_ready && s_last[grant]) begin
          rr_ptr_nxt = (int'(grant) == NUM_Q - 1) ? '0 : grant + QID_W'(1);
          state_nxt  = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Data path is a pure mux on the held grant so beats pass with no added latency.
  assign m_data = s_data[int'(grant)*RX_LEN +: RX_LEN];
  assign m_ben  = s_ben[int'(grant)*RX_BEN +: RX_BEN];
  assign m_qid  = grant;

endmodule

// File: tb/tb_c2h_queue_sched.sv
// tb/tb_c2h_queue_sched.sv - self-checking bench for c2h_queue_sched
module tb_c2h_queue_sched;
  localparam int NQ  = 5;
  localparam int RXL = 512;
  localparam int RXB = RXL / 8;
  localparam int TMB = 16;
  localparam int QW  = 3;

  logic              axi_aclk = 1'b0;
  logic              axi_aresetn = 1'b0;
  logic [NQ-1:0]     q_enable = '0;
  logic              credit_updt = 1'b0;
  logic [QW-1:0]     credit_qid = '0;
  logic [TMB-1:0]    credit_in = '0;
  logic [NQ-1:0]     s_valid;
  logic [NQ*RXL-1:0] s_data;
  logic [NQ*RXB-1:0] s_ben;
  logic [NQ-1:0]     s_last;
  logic [NQ-1:0]     s_ready;
  logic              m_ready;
  logic              m_valid;
  logic [RXL-1:0]    m_data;
  logic [RXB-1:0]    m_ben;
  logic              m_last;
  logic [QW-1:0]     m_qid;
  logic [NQ*TMB-1:0] credit_avail;

  c2h_queue_sched #(.NUM_Q(NQ), .RX_LEN(RXL), .RX_BEN(RXB), .TM_DSC_BITS(TMB), .QID_W(QW)) dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn), .q_enable(q_enable),
    .credit_updt(credit_updt), .credit_qid(credit_qid), .credit_in(credit_in),
    .s_valid(s_valid), .s_data(s_data), .s_ben(s_ben), .s_last(s_last), .s_ready(s_ready),
    .m_ready(m_ready), .m_valid(m_valid), .m_data(m_data), .m_ben(m_ben), .m_last(m_last),
    .m_qid(m_qid), .credit_avail(credit_avail)
  );

  always #5 axi_aclk = ~axi_aclk;

  int checks = 0;
  int failures = 0;

  // Source-side state (what each generator is sending)
  int src_len[NQ], src_left[NQ], src_beat[NQ], src_pkt[NQ];
  // Output-side model (what C2H must see)
  int mdl_len[NQ], mdl_beat[NQ], mdl_pkt[NQ];
  int exp_order[$];
  int pkts_out = 0, beats_out = 0, lasts_out = 0;
  logic bp_mode = 1'b0;

  function automatic logic [RXL-1:0] pat_data(input int q, input int p, input int b);
    logic [RXL-1:0] d;
    d = '0;
    d[31:0] = {8'(q), 8'(p), 16'(b)};
    d[RXL-1 -: 32] = ~d[31:0];
    return d;
  endfunction

  function automatic logic [RXB-1:0] pat_ben(input int b);
    logic [RXB-1:0] all1;
    all1 = '1;
    return all1 >> (b % 8);
  endfunction

  function automatic int cred(input int q);
    return int'(credit_avail[q*TMB +: TMB]);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic quiet();
    @(negedge axi_aclk);
    #2;
  endtask

  task automatic give_credit(input int q, input int n);
    @(posedge axi_aclk); #1;
    credit_updt = 1'b1; credit_qid = QW'(q); credit_in = TMB'(n);
    @(posedge axi_aclk); #1;
    credit_updt = 1'b0; credit_qid = '0; credit_in = '0;
  endtask

  task automatic wait_pkts(input int target, input int budget);
    int n = 0;
    while (pkts_out < target && n < budget) begin
      @(negedge axi_aclk);
      n++;
    end
    chk("pkts_reached", pkts_out, target);
  endtask

  task automatic start_src(input int q, input int len, input int npkts);
    src_len[q] = len; mdl_len[q] = len; src_left[q] = npkts;
  endtask

  // Source generators plus m_ready pattern; inputs change 1 time unit after the clock edge.
  initial begin
    logic [NQ-1:0] fire;
    for (int q = 0; q < NQ; q++) begin
      src_len[q] = 1; src_left[q] = 0; src_beat[q] = 0; src_pkt[q] = 0;
      mdl_len[q] = 1; mdl_beat[q] = 0; mdl_pkt[q] = 0;
    end
    s_valid = '0; s_data = '0; s_ben = '0; s_last = '0; m_ready = 1'b1;
    forever begin
      @(negedge axi_aclk);
      fire = s_valid & s_ready;
      @(posedge axi_aclk); #1;
      for (int q = 0; q < NQ; q++) begin
        if (fire[q]) begin
          src_beat[q]++;
          if (src_beat[q] == src_len[q]) begin
            src_beat[q] = 0; src_pkt[q]++; src_left[q]--;
          end
        end
        s_valid[q] = (src_left[q] > 0);
        s_data[q*RXL +: RXL] = pat_data(q, src_pkt[q], src_beat[q]);
        s_ben[q*RXB +: RXB] = pat_ben(src_beat[q]);
        s_last[q] = s_valid[q] && (src_beat[q] == src_len[q] - 1);
      end
      m_ready = bp_mode ? ~m_ready : 1'b1;
    end
  end

  // Output compare against the model on every valid cycle.
  initial begin
    forever begin
      @(negedge axi_aclk);
      if (axi_aresetn && m_valid) begin
        int q;
        q = int'(m_qid);
        if (q >= NQ) begin
          chk("qid_range", q, 0);
        end else begin
          checks++;
          if (m_data !== pat_data(q, mdl_pkt[q], mdl_beat[q])) begin
            failures++;
            $display("FAIL data q=%0d actual=%h expected=%h", q, m_data[31:0], pat_data(q, mdl_pkt[q], mdl_beat[q]) & 512'hFFFFFFFF);
          end
          chk("ben", m_ben, pat_ben(mdl_beat[q]));
          chk("last", m_last, (mdl_beat[q] == mdl_len[q] - 1));
          chk("s_ready", s_ready, m_ready ? (1 << q) : 0);
          if (m_ready) begin
            if (mdl_beat[q] == 0)
              chk("grant_order", q, (exp_order.size() > 0) ? exp_order.pop_front() : -1);
            beats_out++;
            if (m_last) lasts_out++;
            mdl_beat[q]++;
            if (mdl_beat[q] == mdl_len[q]) begin
              mdl_beat[q] = 0; mdl_pkt[q]++; pkts_out++;
            end
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, bbase, lbase, n;
    // Reset state
    repeat (3) @(posedge axi_aclk);
    #2;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_qid", m_qid, 0);
    for (int q = 0; q < NQ; q++) chk("rst_credit", cred(q), 0);
    quiet();
    axi_aresetn = 1'b1;
    q_enable = '1;
    repeat (3) @(posedge axi_aclk);

    // Four queues, two credits each: strict rotation 0..3 twice, then nothing
    for (int q = 0; q < 4; q++) give_credit(q, 2);
    for (int q = 0; q < 4; q++) chk("cred_init2", cred(q), 2);
    quiet();
    base = pkts_out;
    for (int r = 0; r < 2; r++) for (int q = 0; q < 4; q++) exp_order.push_back(q);
    for (int q = 0; q < 4; q++) start_src(q, 1, 3);
    wait_pkts(base + 8, 300);
    repeat (20) @(posedge axi_aclk);
    quiet();
    chk("rr_pkts", pkts_out - base, 8);
    chk("rr_order_left", exp_order.size(), 0);
    chk("rr_m_valid_idle", m_valid, 0);
    for (int q = 0; q < 4; q++) chk("rr_credit_zero", cred(q), 0);
    for (int q = 0; q < 4; q++) src_left[q] = 0;
    repeat (3) @(posedge axi_aclk);

    // Single queue: 3 credits, 4 packets offered, 4th blocked
    give_credit(0, 3);
    chk("q0_credit3", cred(0), 3);
    quiet();
    base = pkts_out;
    repeat (3) exp_order.push_back(0);
    start_src(0, 1, 4);
    wait_pkts(base + 3, 200);
    repeat (20) @(posedge axi_aclk);
    quiet();
    chk("q0_pkts", pkts_out - base, 3);
    chk("q0_credit0", cred(0), 0);
    chk("q0_blocked_valid", s_valid[0], 1);
    chk("q0_blocked_m_valid", m_valid, 0);
    src_left[0] = 0;
    repeat (3) @(posedge axi_aclk);

    // Backpressure on a 24-beat packet
    give_credit(1, 1);
    quiet();
    base = pkts_out; bbase = beats_out; lbase = lasts_out;
    exp_order.push_back(1);
    bp_mode = 1'b1;
    start_src(1, 24, 1);
    wait_pkts(base + 1, 300);
    repeat (5) @(posedge axi_aclk);
    quiet();
    bp_mode = 1'b0;
    chk("bp_beats", beats_out - bbase, 24);
    chk("bp_lasts", lasts_out - lbase, 1);
    chk("bp_credit", cred(1), 0);
    repeat (3) @(posedge axi_aclk);

    // Credit update coinciding with the grant of the last credit
    give_credit(2, 1);
    repeat (5) @(posedge axi_aclk);
    quiet();
    base = pkts_out;
    exp_order.push_back(2);
    start_src(2, 1, 1);
    @(posedge axi_aclk); #1;
    credit_updt = 1'b1; credit_qid = 3'd2; credit_in = 16'd5;
    @(posedge axi_aclk); #1;
    credit_updt = 1'b0; credit_in = '0; credit_qid = '0;
    wait_pkts(base + 1, 100);
    repeat (5) @(posedge axi_aclk);
    quiet();
    chk("same_cycle_credit", cred(2), 5);

    // Saturation, out-of-range qid, disabled queue
    give_credit(1, 16'hFFF0);
    chk("sat_pre", cred(1), 16'hFFF0);
    give_credit(1, 16'h0020);
    chk("sat_clamp", cred(1), 16'hFFFF);
    give_credit(NQ, 7);
    chk("oor_q0", cred(0), 0);
    chk("oor_q1", cred(1), 16'hFFFF);
    chk("oor_q2", cred(2), 5);
    chk("oor_q3", cred(3), 0);
    chk("oor_q4", cred(4), 0);
    quiet();
    q_enable[3] = 1'b0;
    give_credit(3, 9);
    chk("disabled_drop", cred(3), 0);
    quiet();
    q_enable[2] = 1'b0;
    @(posedge axi_aclk); #2;
    chk("disable_clear", cred(2), 0);
    q_enable = '1;

    // Reset during beat 10 of a 24-beat packet
    give_credit(0, 1);
    quiet();
    exp_order.push_back(0);
    start_src(0, 24, 1);
    n = 0;
    while (mdl_beat[0] != 9 && n < 200) begin quiet(); n++; end
    chk("reach_beat10", mdl_beat[0], 9);
    @(negedge axi_aclk); #2;
    axi_aresetn = 1'b0;
    #1;
    chk("rst_mid_m_valid", m_valid, 0);
    chk("rst_mid_s_ready", s_ready, 0);
    chk("rst_mid_m_last", m_last, 0);
    repeat (2) @(posedge axi_aclk);
    quiet();
    for (int q = 0; q < NQ; q++) begin
      src_left[q] = 0; src_beat[q] = 0; mdl_beat[q] = 0;
    end
    exp_order.delete();
    repeat (2) @(posedge axi_aclk);
    quiet();
    axi_aresetn = 1'b1;
    @(negedge axi_aclk); #2;
    for (int q = 0; q < NQ; q++) chk("post_rst_credit", cred(q), 0);
    chk("post_rst_m_qid", m_qid, 0);
    chk("post_rst_s_ready", s_ready, 0);
    repeat (10) @(posedge axi_aclk);
    quiet();
    chk("post_rst_m_valid", m_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
